// File: rtl/fp_round_pipe_pkg.sv
// Shared definitions for the FP rounding datapath: format lengths, rounding modes,
// special-value codes and exception-flag bit positions.
package fp_round_pipe_pkg;

    localparam int FP16 = 0;
    localparam int FP32 = 1;
    localparam int FP64 = 2;

    function automatic int get_exp_len(input int fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int get_mantissa_len(input int fmt);
        case (fmt)
            FP16:    return 10;
            FP64:    return 52;
            default: return 23;
        endcase
    endfunction

    function automatic int get_protect_len(input int fmt);
        case (fmt)
            FP16:    return 3;
            FP64:    return 3;
            default: return 3;
        endcase
    endfunction

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'd0,
        SP_ZERO   = 2'd1,
        SP_INF    = 2'd2,
        SP_NAN    = 2'd3
    } special_e;

    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_round_decide.sv
// Rounding decision: extracts guard/round/sticky from the protect bits and
// decides whether to increment the kept significand for the given mode.
module fp_round_decide
    import fp_round_pipe_pkg::*;
#(
    parameter int PROTECT_LEN = 3
) (
    input  logic [PROTECT_LEN-1:0] protect,
    input  logic                   lsb,
    input  logic                   sign,
    input  rm_e                    rm,
    output logic                   round_up,
    output logic                   inexact
);

    logic g;
    logic r;
    logic s;

    assign g = protect[PROTECT_LEN-1];

    if (PROTECT_LEN >= 2) begin : g_round_bit
        assign r = protect[PROTECT_LEN-2];
    end else begin : g_no_round_bit
        assign r = 1'b0;
    end

    if (PROTECT_LEN >= 3) begin : g_sticky_bit
        assign s = |protect[PROTECT_LEN-3:0];
    end else begin : g_no_sticky_bit
        assign s = 1'b0;
    end

    assign inexact = g | r | s;

    // NOTE: default assigned first so every path drives round_up and no latch is inferred.
    always_comb begin
        round_up = 1'b0;
        unique case (rm)
            RM_RNE:  round_up = g & (r | s | lsb);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & inexact;
            RM_RUP:  round_up = !sign & inexact;
            RM_RMM:  round_up = g;
            default: round_up = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined rounder/packer with valid/ready on both sides.
// Define FP_ROUND_FLAGS_EN to add the out_flags port {overflow, underflow, inexact}.
module fp_round_pipe
    import fp_round_pipe_pkg::*;
#(
    parameter int         data_format = FP32,
    parameter logic [2:0] DEFAULT_RM  = 3'd0,
    localparam int EXP_LEN     = get_exp_len(data_format),
    localparam int MANT_LEN    = get_mantissa_len(data_format),
    localparam int PROTECT_LEN = get_protect_len(data_format),
    localparam int SIG_LEN     = MANT_LEN + PROTECT_LEN + 1,
    localparam int FP_LEN      = 1 + EXP_LEN + MANT_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_special,
    input  logic               in_sign,
    input  logic [EXP_LEN-1:0] in_exp,
    input  logic [SIG_LEN-1:0] in_mant,
    input  logic [2:0]         in_rm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_LEN-1:0]  out_result
`ifdef FP_ROUND_FLAGS_EN
    ,
    output logic [2:0]         out_flags
`endif
);

    localparam logic [EXP_LEN:0] EXP_ONES = {1'b0, {EXP_LEN{1'b1}}};

    logic s1_en;
    logic s2_en;
    logic s1_valid;
    logic s2_valid;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    // Stage 1: decide rounding and increment the kept significand.
    rm_e                s0_rm;
    logic               s0_round_up;
    logic               s0_inexact;
    logic [MANT_LEN+1:0] s0_rounded;

    assign s0_rm = (in_rm > 3'd4) ? rm_e'(DEFAULT_RM) : rm_e'(in_rm);

    fp_round_decide #(.PROTECT_LEN(PROTECT_LEN)) u_decide (
        .protect  (in_mant[PROTECT_LEN-1:0]),
        .lsb      (in_mant[PROTECT_LEN]),
        .sign     (in_sign),
        .rm       (s0_rm),
        .round_up (s0_round_up),
        .inexact  (s0_inexact)
    );

    assign s0_rounded = {1'b0, in_mant[SIG_LEN-1:PROTECT_LEN]}
                      + {{(MANT_LEN+1){1'b0}}, s0_round_up};

    logic [MANT_LEN+1:0] s1_rounded;
    logic                s1_sign;
    logic [EXP_LEN-1:0]  s1_exp;
    logic [1:0]          s1_special;
    rm_e                 s1_rm;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; s1_valid/s2_valid qualify them.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_rounded <= s0_rounded;
            s1_sign    <= in_sign;
            s1_exp     <= in_exp;
            s1_special <= in_special;
            s1_rm      <= s0_rm;
        end
    end

    // Stage 2: exponent adjust, overflow saturation and special override.
    logic [EXP_LEN:0]    s2_exp_adj;
    logic [MANT_LEN-1:0] s2_mant_adj;
    logic                s2_overflow;
    logic                s2_to_inf;
    logic [FP_LEN-1:0]   s2_result_d;

    always_comb begin
        s2_exp_adj  = {1'b0, s1_exp};
        s2_mant_adj = s1_rounded[MANT_LEN-1:0];
        if (s1_rounded[MANT_LEN+1]) begin
            s2_exp_adj  = {1'b0, s1_exp} + (EXP_LEN+1)'(1);
            s2_mant_adj = s1_rounded[MANT_LEN:1];
        end else if (s1_exp == '0 && s1_rounded[MANT_LEN]) begin
            s2_exp_adj  = (EXP_LEN+1)'(1);
        end

        s2_overflow = (s2_exp_adj >= EXP_ONES);
        s2_to_inf   = (s1_rm == RM_RNE) || (s1_rm == RM_RMM) ||
                      (s1_rm == RM_RUP && !s1_sign) || (s1_rm == RM_RDN && s1_sign);

        unique case (s1_special)
            SP_INF:  s2_result_d = {s1_sign, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
            SP_NAN:  s2_result_d = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANT_LEN-1){1'b0}}};
            SP_ZERO: s2_result_d = {s1_sign, {EXP_LEN{1'b0}}, {MANT_LEN{1'b0}}};
            default: begin
                if (s2_overflow && s2_to_inf) begin
                    s2_result_d = {s1_sign, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
                end else if (s2_overflow) begin
                    s2_result_d = {s1_sign, {(EXP_LEN-1){1'b1}}, 1'b0, {MANT_LEN{1'b1}}};
                end else begin
                    s2_result_d = {s1_sign, s2_exp_adj[EXP_LEN-1:0], s2_mant_adj};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= s2_result_d;
            end
        end
    end

`ifdef FP_ROUND_FLAGS_EN
    logic       s1_inexact;
    logic [2:0] s2_flags_d;
    logic       s2_is_normal;

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_inexact <= s0_inexact;
        end
    end

    // Specials report no exceptions; overflow is always inexact.
    always_comb begin
        s2_is_normal        = (s1_special == SP_NORMAL);
        s2_flags_d          = '0;
        s2_flags_d[FLAG_OF] = s2_is_normal && s2_overflow;
        s2_flags_d[FLAG_UF] = s2_is_normal && (s1_exp == '0) && s1_inexact;
        s2_flags_d[FLAG_NX] = s2_is_normal && (s1_inexact || s2_overflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_flags <= '0;
        end else if (s2_en && s1_valid) begin
            out_flags <= s2_flags_d;
        end
    end
`else
    logic nx_unused;
    assign nx_unused = s0_inexact;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe (FP32): directed vector table, handshake
// corner sequences and randomized beats against an arithmetic reference model.
module tb_fp_round_pipe;
    import fp_round_pipe_pkg::*;

    localparam int P = 3;
    localparam int M = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_special;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FP_ROUND_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    fp_round_pipe #(.data_format(FP32), .DEFAULT_RM(3'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_special (in_special),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FP_ROUND_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sp;
        logic        sg;
        logic [7:0]  ex;
        logic [26:0] mt;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_out = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
        else n_pass++;
    endtask

    function automatic logic [26:0] mk(input logic h, input logic [22:0] f, input logic [2:0] p);
        return {h, f, p};
    endfunction

    // Reference: value-level rounding of sig + rem/2^P, then exponent/overflow rules.
    function automatic exp_t ref_model(input logic [1:0] sp, input logic sg, input logic [7:0] ex,
                                       input logic [26:0] mt, input logic [2:0] rm_in);
        exp_t   r;
        longint sig, rem, half, val;
        int     e, rm;
        bit     up, of, to_inf;
        r.flg = 3'b000;
        rm = (rm_in > 3'd4) ? 0 : int'(rm_in);
        if (sp == SP_ZERO) begin r.res = {sg, 31'd0}; return r; end
        if (sp == SP_INF)  begin r.res = {sg, 8'hFF, 23'd0}; return r; end
        if (sp == SP_NAN)  begin r.res = 32'h7FC0_0000; return r; end
        sig  = longint'(mt) / (64'd1 << P);
        rem  = longint'(mt) % (64'd1 << P);
        half = 64'd1 << (P - 1);
        case (rm)
            0:       up = (rem > half) || (rem == half && (sig % 2) == 1);
            1:       up = 0;
            2:       up = sg && rem != 0;
            3:       up = !sg && rem != 0;
            default: up = rem >= half;
        endcase
        val = sig + (up ? 1 : 0);
        e   = int'(ex);
        if (val >= (64'd1 << (M + 1))) begin
            val = val / 2;
            e   = e + 1;
        end else if (e == 0 && val >= (64'd1 << M)) begin
            e = 1;
        end
        of     = (e >= 255);
        to_inf = (rm == 0) || (rm == 4) || (rm == 3 && !sg) || (rm == 2 && sg);
        if (of && to_inf) r.res = {sg, 8'hFF, 23'd0};
        else if (of)      r.res = {sg, 8'hFE, 23'h7FFFFF};
        else              r.res = {sg, 8'(e), 23'(val % (64'd1 << M))};
        r.flg = {of, (ex == 0) && rem != 0, (rem != 0) || of};
        return r;
    endfunction

    task automatic apply(input logic [1:0] sp, input logic sg, input logic [7:0] ex,
                         input logic [26:0] mt, input logic [2:0] rm);
        in_special = sp;
        in_sign    = sg;
        in_exp     = ex;
        in_mant    = mt;
        in_rm      = rm;
    endtask

    // One cycle: called at a negedge with inputs set; compares any presented result.
    task automatic step(output bit acc);
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious out_valid", 64'd1, 64'd0);
            end else begin
                check("result", out_result, exp_q[0].res);
`ifdef FP_ROUND_FLAGS_EN
                check("flags", out_flags, exp_q[0].flg);
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        acc = in_valid && in_ready && !rst;
        if (acc) exp_q.push_back(cur);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] sp, input logic sg, input logic [7:0] ex,
                        input logic [26:0] mt, input logic [2:0] rm, input exp_t e);
        bit acc;
        int guard;
        apply(sp, sg, ex, mt, rm);
        cur      = e;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            step(acc);
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("accept timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(acc);
        check("drain leftover", exp_q.size(), 0);
    endtask

    task automatic rand_beat();
        logic [1:0]  sp;
        logic        sg;
        logic [7:0]  ex;
        logic [26:0] mt;
        logic [2:0]  rm;
        int          k;
        k  = $urandom_range(99);
        sp = (k < 88) ? 2'd0 : 2'($urandom_range(3));
        sg = 1'($urandom_range(1));
        k  = $urandom_range(9);
        ex = (k == 0) ? 8'h00 : (k == 1) ? 8'hFE : (k == 2) ? 8'hFF : 8'($urandom_range(1, 253));
        mt = 27'($urandom);
        mt[26] = (ex != 8'h00);
        if ($urandom_range(3) == 0) mt[25:3] = '1;
        rm = 3'($urandom_range(7));
        apply(sp, sg, ex, mt, rm);
        cur = ref_model(sp, sg, ex, mt, rm);
    endtask

    vec_t vecs[$];

    initial begin
        bit acc;
        int base;
        int acc_cnt;
        bit have;

        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int base;
        int acc_cnt;
        bit have;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        apply(2'd0, 1'b0, 8'd0, 27'd0, 3'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset out_result", out_result, 0);
`ifdef FP_ROUND_FLAGS_EN
        check("reset out_flags", out_flags, 0);
`endif
        @(negedge clk);

        // Latency: accepted beat appears on the second cycle after acceptance.
        out_ready = 1'b1;
        apply(SP_NORMAL, 1'b0, 8'h7F, mk(1'b1, 23'd1, 3'b100), RM_RNE);
        cur = '{32'h3F80_0002, 3'b001};
        in_valid = 1'b1;
        step(acc);
        check("latency accept", acc, 1);
        in_valid = 1'b0;
        #1 check("latency cycle1 out_valid", out_valid, 0);
        step(acc);
        #1 check("latency cycle2 out_valid", out_valid, 1);
        step(acc);
        check("latency popped", exp_q.size(), 0);

        // Directed vectors {special, sign, exp, mant, rm, result, {OF,UF,NX}}.
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd0, 3'b100), RM_RNE, 32'h3F80_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd1, 3'b100), RM_RNE, 32'h3F80_0002, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd0, 3'b010), RM_RUP, 32'h3F80_0001, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b1, 8'h7F, mk(1, 23'd0, 3'b010), RM_RUP, 32'hBF80_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b1, 8'h7F, mk(1, 23'd0, 3'b010), RM_RDN, 32'hBF80_0001, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd0, 3'b010), RM_RDN, 32'h3F80_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd0, 3'b010), RM_RTZ, 32'h3F80_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b1, 8'h7F, mk(1, 23'd0, 3'b010), RM_RTZ, 32'hBF80_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd0, 3'b010), RM_RMM, 32'h3F80_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd0, 3'b100), RM_RMM, 32'h3F80_0001, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'hFE, mk(1, '1, 3'b100), RM_RNE, 32'h7F80_0000, 3'b101});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'hFE, mk(1, '1, 3'b100), RM_RTZ, 32'h7F7F_FFFF, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b1, 8'hFE, mk(1, '1, 3'b100), RM_RDN, 32'hFF80_0000, 3'b101});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'hFE, mk(1, '1, 3'b100), RM_RUP, 32'h7F80_0000, 3'b101});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'hFF, mk(1, 23'd0, 3'b000), RM_RTZ, 32'h7F7F_FFFF, 3'b101});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h00, mk(0, '1, 3'b100), RM_RNE, 32'h0080_0000, 3'b011});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h00, mk(0, 23'd5, 3'b000), RM_RNE, 32'h0000_0005, 3'b000});
        vecs.push_back('{SP_NAN,    1'b1, 8'h12, mk(1, '1, 3'b111), RM_RUP, 32'h7FC0_0000, 3'b000});
        vecs.push_back('{SP_ZERO,   1'b1, 8'h00, mk(0, 23'd0, 3'b111), RM_RNE, 32'h8000_0000, 3'b000});
        vecs.push_back('{SP_INF,    1'b1, 8'h33, mk(1, 23'd9, 3'b101), RM_RTZ, 32'hFF80_0000, 3'b000});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd1, 3'b100), 3'd7,   32'h3F80_0002, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, 23'd1, 3'b011), 3'd5,   32'h3F80_0001, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h7F, mk(1, '1, 3'b110), RM_RNE, 32'h4000_0000, 3'b001});
        vecs.push_back('{SP_NORMAL, 1'b0, 8'h80, mk(1, 23'd3, 3'b000), RM_RNE, 32'h4000_0003, 3'b000});

        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].sp, vecs[i].sg, vecs[i].ex, vecs[i].mt, vecs[i].rm,
                 '{vecs[i].res, vecs[i].flg});
        end
        drain();

        // Backpressure: out_ready low for three cycles with four back-to-back beats.
        base      = n_out;
        acc_cnt   = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_beat();
            step(acc);
            check("backpressure in_ready", acc, (c < 2) ? 1 : 0);
            if (acc) acc_cnt++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc_cnt < 4; c++) begin
            if (c != 0) rand_beat();
            in_valid = 1'b1;
            step(acc);
            if (acc) acc_cnt++;
        end
        in_valid = 1'b0;
        drain();
        check("backpressure beats out", n_out - base, 4);

        // Reset with two beats in flight: nothing from them may appear afterwards.
        out_ready = 1'b0;
        rand_beat();
        send(in_special, in_sign, in_exp, in_mant, in_rm, cur);
        rand_beat();
        send(in_special, in_sign, in_exp, in_mant, in_rm, cur);
        check("inflight count", exp_q.size(), 2);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("post-reset out_valid", out_valid, 0);
        check("post-reset in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            #1 check("no stale output", out_valid, 0);
            step(acc);
        end

        // Randomized traffic with random stalls on both sides.
        have = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                rand_beat();
                have = ($urandom_range(9) < 7);
            end
            in_valid  = have;
            out_ready = ($urandom_range(9) < 7);
            step(acc);
            if (acc) have = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
